// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Receive-side counterpart of a multiplexed BCD-to-7-segment driver. The
// active-low segment bus and digit-select lines are sampled and each settled
// glyph is decoded back to its 4-bit value. One value is collected per digit
// position. When every position has been seen, the frame is published with a
// single-cycle valid pulse.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digit positions (1..8)
//   STABLE_CYCLES  identical consecutive samples needed to accept a digit (2..255)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   seg_n      in   segments a..g on bits 0..6, active low
//   an_n       in   digit selects, active low, one-hot-low when valid
//   digitos    out  published frame, nibble i = value of position i
//   invalido   out  bit i set when position i held an illegal glyph
//   quadro_ok  out  one-cycle pulse when digitos/invalido update
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] digitos,
    output logic [NUM_DIGITS-1:0]   invalido,
    output logic                    quadro_ok
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ESPERA,
        CONTA,
        TRAVADO
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_next;
    logic                    commit;

    logic [6:0]              s_seg;
    logic [NUM_DIGITS-1:0]   s_an;
    logic [6:0]              p_seg;
    logic [NUM_DIGITS-1:0]   p_an;

    logic [3:0]              dec_val;
    logic                    dec_bad;
    logic                    an_one_hot;
    logic                    changed;
    logic                    frame_done;

    logic [NUM_DIGITS-1:0]   mask;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_inv;

    // Input stage plus a one-cycle-older copy; "unchanged" means the newest
    // registered sample matches the one before it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_seg <= 7'h7F;
            s_an  <= '1;
            p_seg <= 7'h7F;
            p_an  <= '1;
        end else begin
            s_seg <= seg_n;
            s_an  <= an_n;
            p_seg <= s_seg;
            p_an  <= s_an;
        end
    end

    // Glyph decode, active low with bits g..a; anything else is illegal.
    always_comb begin
        dec_val = 4'hF;
        dec_bad = 1'b0;
        case (s_seg)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            default:    dec_bad = 1'b1;
        endcase
    end

    assign an_one_hot = $onehot(~s_an);
    assign changed    = (s_seg != p_seg) || (s_an != p_an);
    assign frame_done = &mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ESPERA;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Stability FSM. The counter holds the number of identical samples seen
    // in the current run; reaching STABLE_CYCLES commits exactly once and
    // then parks in TRAVADO with the counter saturated until the bus moves.
    always_comb begin
        state_next = state;
        count_next = count;
        commit     = 1'b0;
        case (state)
            ESPERA: begin
                count_next = '0;
                if (an_one_hot) begin
                    state_next = CONTA;
                    count_next = CW'(1);
                end
            end
            CONTA: begin
                if (changed) begin
                    if (an_one_hot) begin
                        count_next = CW'(1);
                    end else begin
                        state_next = ESPERA;
                        count_next = '0;
                    end
                end else if (count >= CW'(STABLE_CYCLES - 1)) begin
                    state_next = TRAVADO;
                    count_next = CW'(STABLE_CYCLES);
                    commit     = 1'b1;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            TRAVADO: begin
                if (changed) begin
                    if (an_one_hot) begin
                        state_next = CONTA;
                        count_next = CW'(1);
                    end else begin
                        state_next = ESPERA;
                        count_next = '0;
                    end
                end
            end
            default: begin
                state_next = ESPERA;
                count_next = '0;
            end
        endcase
    end

    // Pending slots and position mask. A commit is only raised while s_an is
    // one-hot-low, so ~s_an is directly the mask bit of the committing
    // position. A commit landing on the completion edge survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask     <= '0;
            pend_val <= '0;
            pend_inv <= '0;
        end else begin
            mask <= (frame_done ? '0 : mask) | (commit ? ~s_an : '0);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (commit && !s_an[i]) begin
                    pend_val[4*i +: 4] <= dec_val;
                    pend_inv[i]        <= dec_bad;
                end
            end
        end
    end

    // Frame publication, one edge after the mask fills.
    always_ff @(posedge clk) begin
        if (reset) begin
            digitos   <= '0;
            invalido  <= '0;
            quadro_ok <= 1'b0;
        end else begin
            quadro_ok <= frame_done;
            if (frame_done) begin
                digitos  <= pend_val;
                invalido <= pend_inv;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Self-checking bench for seg7_scan_decoder. The bus is driven as a series of
// "holds" (a segment/select pattern kept for N cycles). A reference model
// reasons in terms of whole holds: a one-hot-low select pattern kept for at
// least STABLE_CYCLES samples commits its glyph once, and a frame is expected
// whenever every position has committed. Published frames are captured by a
// monitor and compared against the model's expected frame list.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 4;
    localparam int FW = 5 * ND;

    logic              clk = 1'b0;
    logic              reset;
    logic [6:0]        seg_n;
    logic [ND-1:0]     an_n;
    logic [4*ND-1:0]   digitos;
    logic [ND-1:0]     invalido;
    logic              quadro_ok;

    int check_count = 0;
    int error_count = 0;

    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic [FW-1:0] got_frames [$];
    logic [FW-1:0] exp_frames [$];

    logic [3:0]    m_val [ND];
    logic          m_inv [ND];
    logic [ND-1:0] m_got;
    logic [FW-1:0] m_pub;
    logic [6:0]    m_prev_seg;
    logic [ND-1:0] m_prev_an;
    int            m_run;
    bit            m_done;

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .digitos   (digitos),
        .invalido  (invalido),
        .quadro_ok (quadro_ok)
    );

    always #5 clk = ~clk;

    // Capture every published frame mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (quadro_ok === 1'b1) got_frames.push_back({invalido, digitos});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) else begin
            error_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] packFrame();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < ND; i++) begin
            f[4*i +: 4] = m_val[i];
            f[4*ND + i] = m_inv[i];
        end
        return f;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ND; i++) begin
            m_val[i] = 4'h0;
            m_inv[i] = 1'b0;
        end
        m_got      = '0;
        m_pub      = '0;
        m_prev_seg = 7'h7F;
        m_prev_an  = '1;
        m_run      = 0;
        m_done     = 1'b0;
    endtask

    // A run is the total length of consecutive identical holds; it commits
    // once, when it is one-hot-low and has lasted at least S samples.
    task automatic modelHold(input logic [6:0] seg, input logic [ND-1:0] an, input int n);
        int zeros;
        int pos;
        logic [3:0] val;
        logic inv;
        if (seg == m_prev_seg && an == m_prev_an) begin
            m_run += n;
        end else begin
            m_run  = n;
            m_done = 1'b0;
        end
        m_prev_seg = seg;
        m_prev_an  = an;
        zeros = 0;
        pos   = 0;
        for (int i = 0; i < ND; i++) begin
            if (an[i] == 1'b0) begin
                zeros++;
                pos = i;
            end
        end
        if (zeros == 1 && !m_done && m_run >= S) begin
            m_done = 1'b1;
            val = 4'hF;
            inv = 1'b1;
            for (int d = 0; d < 10; d++) begin
                if (glyph[d] == seg) begin
                    val = 4'(d);
                    inv = 1'b0;
                end
            end
            m_val[pos] = val;
            m_inv[pos] = inv;
            m_got[pos] = 1'b1;
            if (&m_got) begin
                m_pub = packFrame();
                exp_frames.push_back(m_pub);
                m_got = '0;
            end
        end
    endtask

    task automatic applyStimulus(input logic [6:0] seg, input logic [ND-1:0] an, input int n);
        seg_n = seg;
        an_n  = an;
        modelHold(seg, an, n);
        repeat (n) stepCycle();
    endtask

    task automatic doReset();
        reset = 1'b1;
        seg_n = 7'h7F;
        an_n  = '1;
        stepCycle();
        reset = 1'b0;
        modelReset();
    endtask

    // Let the bus go idle long enough for any pending publication, then
    // compare captured frames against the model's expected list.
    task automatic checkFrames(input string tag);
        logic [FW-1:0] g;
        logic [FW-1:0] e;
        applyStimulus(7'h7F, '1, S + 4);
        checkOutput({tag, "_count"}, got_frames.size(), exp_frames.size());
        while (got_frames.size() > 0 && exp_frames.size() > 0) begin
            g = got_frames.pop_front();
            e = exp_frames.pop_front();
            checkOutput({tag, "_frame"}, 32'(g), 32'(e));
        end
        checkOutput({tag, "_published"}, 32'({invalido, digitos}), 32'(m_pub));
        got_frames.delete();
        exp_frames.delete();
    endtask

    initial begin
        logic [6:0]    rs;
        logic [ND-1:0] ra;
        reset = 1'b1;
        seg_n = 7'h7F;
        an_n  = '1;
        stepCycle();
        doReset();
        checkOutput("reset_digitos", 32'(digitos), 32'h0);
        checkOutput("reset_invalido", 32'(invalido), 32'h0);
        checkOutput("reset_quadro_ok", 32'(quadro_ok), 32'h0);

        // Glyphs 1,2,3,4 on positions 0..3.
        applyStimulus(glyph[1], 4'b1110, 6);
        applyStimulus(glyph[2], 4'b1101, 6);
        applyStimulus(glyph[3], 4'b1011, 6);
        applyStimulus(glyph[4], 4'b0111, 6);
        checkFrames("frame1234");
        checkOutput("frame1234_digitos", 32'(digitos), 32'h4321);
        checkOutput("frame1234_invalido", 32'(invalido), 32'h0);

        // Blank glyph on position 2 is illegal.
        applyStimulus(glyph[5], 4'b1110, 6);
        applyStimulus(glyph[6], 4'b1101, 6);
        applyStimulus(7'h7F,    4'b1011, 6);
        applyStimulus(glyph[7], 4'b0111, 6);
        checkFrames("blank");
        checkOutput("blank_nibble2", 32'(digitos[11:8]), 32'hF);
        checkOutput("blank_invalido", 32'(invalido), 32'b0100);

        // Position 0 held too briefly: the frame must wait for it.
        applyStimulus(glyph[8], 4'b1110, 3);
        applyStimulus(glyph[1], 4'b1101, 6);
        applyStimulus(glyph[2], 4'b1011, 6);
        applyStimulus(glyph[3], 4'b0111, 6);
        checkFrames("short_hold");
        applyStimulus(glyph[8], 4'b1110, 4);
        checkFrames("short_fill");
        checkOutput("short_fill_digitos", 32'(digitos), 32'h3218);

        // Two selects active: nothing may commit.
        applyStimulus(glyph[0], 4'b1100, 10);
        applyStimulus(glyph[9], 4'b1101, 6);
        applyStimulus(glyph[9], 4'b1011, 6);
        applyStimulus(glyph[9], 4'b0111, 6);
        checkFrames("two_active");
        applyStimulus(glyph[0], 4'b1110, 6);
        checkFrames("two_active_fill");

        // Latency: 5 -> 7 on position 1 as the frame's last commit.
        doReset();
        applyStimulus(glyph[9], 4'b1110, 6);
        applyStimulus(glyph[8], 4'b1011, 6);
        applyStimulus(glyph[6], 4'b0111, 6);
        applyStimulus(glyph[5], 4'b1101, 2);
        seg_n = glyph[7];
        an_n  = 4'b1101;
        modelHold(glyph[7], 4'b1101, 6);
        for (int i = 1; i <= 6; i++) begin
            stepCycle();
            checkOutput("latency_quadro_ok", 32'(quadro_ok), (i == 6) ? 32'h1 : 32'h0);
        end
        checkFrames("latency");
        checkOutput("latency_digitos", 32'(digitos), 32'h6879);

        // Reset mid-frame discards the partial frame.
        applyStimulus(glyph[1], 4'b1110, 6);
        applyStimulus(glyph[2], 4'b1101, 6);
        applyStimulus(glyph[3], 4'b1011, 6);
        doReset();
        checkOutput("midreset_digitos", 32'(digitos), 32'h0);
        checkOutput("midreset_invalido", 32'(invalido), 32'h0);
        checkOutput("midreset_quadro_ok", 32'(quadro_ok), 32'h0);
        applyStimulus(glyph[4], 4'b0111, 6);
        checkFrames("midreset_partial");
        applyStimulus(glyph[5], 4'b1110, 6);
        applyStimulus(glyph[6], 4'b1101, 6);
        applyStimulus(glyph[7], 4'b1011, 6);
        checkFrames("midreset_full");

        // Randomised holds: mostly legal glyphs on single positions, with
        // illegal patterns, multi-select patterns and short holds mixed in.
        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(0, 9) < 7) rs = glyph[$urandom_range(0, 9)];
            else rs = 7'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                ra = '1;
                ra[$urandom_range(0, ND - 1)] = 1'b0;
            end else begin
                ra = ND'($urandom);
            end
            applyStimulus(rs, ra, $urandom_range(1, 7));
            if (r % 40 == 39) checkFrames("random");
        end
        checkFrames("random_end");

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
